// File: rtl/srambank_pkg.sv
// rtl/srambank_pkg.sv - shared bank geometry and sequencer state type
package srambank_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 34;
  localparam int DEPTH  = 1024;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant; the pointer register lives in the parent
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/srambank_arb2.sv
// rtl/srambank_arb2.sv - zero-fill sequencer and two-port round-robin front end for one SRAM bank
module srambank_arb2 #(
  parameter int                ADDR_W   = srambank_pkg::ADDR_W,
  parameter int                DATA_W   = srambank_pkg::DATA_W,
  parameter int                DEPTH    = srambank_pkg::DEPTH,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     bank_address,
  output logic [DATA_W-1:0]     bank_wd,
  output logic                  bank_banksel,
  output logic                  bank_read,
  output logic                  bank_write,
  input  logic [DATA_W-1:0]     bank_dataout
);

  import srambank_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fill_cnt;
  logic              last;
  logic              rd_pend;
  logic              rd_port;
  logic [1:0]        arb_grant;
  logic [1:0]        grant;
  logic              gsel;
  logic              acc;
  logic              acc_read;
  logic              acc_write;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last),
    .grant (arb_grant)
  );

  // Reset masks every client-visible output in the cycle it is asserted.
  assign grant     = (state == RUN && !reset) ? arb_grant : 2'b00;
  assign gsel      = grant[1];
  assign acc       = |grant;
  assign acc_write = acc && req_write[gsel];
  assign acc_read  = acc && !req_write[gsel];

  assign req_ready = grant;
  assign init_done = (state == RUN) && !reset;
  assign rsp_valid = (rd_pend && !reset) ? (rd_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = bank_dataout;

  always_comb begin
    state_nxt    = state;
    bank_banksel = 1'b0;
    bank_read    = 1'b0;
    bank_write   = 1'b0;
    bank_address = gsel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    bank_wd      = gsel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    case (state)
      INIT: begin
        bank_banksel = 1'b1;
        bank_write   = 1'b1;
        bank_address = fill_cnt;
        bank_wd      = INIT_VAL;
        if (fill_cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bank_banksel = acc;
        bank_read    = acc_read;
        bank_write   = acc_write;
      end
      default: state_nxt = INIT;
    endcase
    if (reset) begin
      bank_banksel = 1'b0;
      bank_read    = 1'b0;
      bank_write   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      fill_cnt <= '0;
      last     <= 1'b1;
      rd_pend  <= 1'b0;
      rd_port  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        fill_cnt <= fill_cnt + ADDR_W'(1);
      end
      if (acc) begin
        last <= gsel;
      end
      rd_pend <= acc_read;
      if (acc_read) begin
        rd_port <= gsel;
      end
    end
  end

endmodule

// File: tb/tb_srambank_arb2.sv
// tb/tb_srambank_arb2.sv - scoreboard bench for srambank_arb2 with a behavioural bank
module tb_srambank_arb2;

  localparam int AW    = 10;
  localparam int DW    = 34;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            init_done;
  logic [AW-1:0]   bank_address;
  logic [DW-1:0]   bank_wd;
  logic            bank_banksel;
  logic            bank_read;
  logic            bank_write;
  logic [DW-1:0]   bank_dataout;

  always #5 clk = ~clk;

  srambank_arb2 #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_VAL('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .init_done    (init_done),
    .bank_address (bank_address),
    .bank_wd      (bank_wd),
    .bank_banksel (bank_banksel),
    .bank_read    (bank_read),
    .bank_write   (bank_write),
    .bank_dataout (bank_dataout)
  );

  // Bank: 1-cycle read, dataout held on writes; scramble fills it with garbage.
  logic [DW-1:0] bank_mem [DEPTH];
  logic          scramble;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) bank_mem[i] <= DW'({$urandom(), $urandom()});
    end else begin
      if (bank_banksel && bank_read)  bank_dataout <= bank_mem[bank_address];
      if (bank_banksel && bank_write) bank_mem[bank_address] <= bank_wd;
    end
  end

  typedef struct {
    int            cyc;
    logic [1:0]    ready;
    logic          done;
    int            fill;
    logic          rst;
    logic [AW-1:0] addr;
    logic          wr;
  } exp_t;

  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  exp_t          eq[$];
  rsp_t          rq[$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            post = 0;
  logic          last_m = 1'b1;
  logic          end_req = 1'b0;
  int            errors = 0;
  int            checks = 0;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // One clock of stimulus; the model decides what the DUT must do this cycle.
  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic [1:0] g);
    exp_t e;
    int   cur;
    logic p;
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    cyc++;
    g = 2'b00;
    e = '{cyc: cyc, ready: 2'b00, done: 1'b0, fill: -1, rst: rst, addr: '0, wr: 1'b0};
    if (rst) begin
      post   = 0;
      last_m = 1'b1;
      rq.delete();
      ref_mem.delete();
    end else begin
      cur = post;
      post++;
      if (cur < DEPTH) begin
        e.fill = cur;
      end else begin
        e.done = 1'b1;
        if (v == 2'b11) g = last_m ? 2'b01 : 2'b10;
        else            g = v;
        e.ready = g;
        if (g != 2'b00) begin
          p      = g[1];
          last_m = p;
          e.addr = p ? a1 : a0;
          e.wr   = w[p];
          if (w[p]) ref_mem[int'(e.addr)] = p ? d1 : d0;
          else      rq.push_back('{due: cyc + 1, port: p, data: ref_rd(int'(e.addr))});
        end
      end
    end
    eq.push_back(e);
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, g);
  endtask

  task automatic do_reset();
    logic [1:0] g;
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, g);
    scramble = 1'b1;
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, g);
    scramble = 1'b0;
  endtask

  initial begin
    logic [1:0]    g;
    logic [1:0]    pv;
    logic [1:0]    pw;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    scramble  = 1'b0;

    do_reset();
    idle(DEPTH + 2);
    step(1'b0, 2'b01, 2'b00, 10'h3FF, '0, '0, '0, g);
    idle(2);

    step(1'b0, 2'b01, 2'b01, 10'd5, '0, 34'h2_DEAD_BEEF, '0, g);
    step(1'b0, 2'b10, 2'b00, '0, 10'd5, '0, '0, g);
    idle(2);

    for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 2'b00, 10'(i), 10'd5, '0, '0, g);
    idle(2);

    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 2'b00, '0, 10'(i), '0, '0, g);
    step(1'b0, 2'b11, 2'b00, 10'd5, 10'd7, '0, '0, g);
    idle(2);

    do_reset();
    idle(500);
    do_reset();
    idle(DEPTH + 1);
    step(1'b0, 2'b01, 2'b00, 10'd5, '0, '0, '0, g);
    do_reset();

    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 2'b11, 2'b00, 10'd1, 10'd2, '0, '0, g);
    idle(2);

    pv = 2'b00;
    pw = 2'b00;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv[0] && $urandom_range(0, 2) != 0) begin
        pv[0] = 1'b1; pw[0] = 1'($urandom());
        pa0 = 10'($urandom_range(0, 15)); pd0 = DW'({$urandom(), $urandom()});
      end
      if (!pv[1] && $urandom_range(0, 2) != 0) begin
        pv[1] = 1'b1; pw[1] = 1'($urandom());
        pa1 = 10'($urandom_range(0, 15)); pd1 = DW'({$urandom(), $urandom()});
      end
      step(1'b0, pv, pw, pa0, pa1, pd0, pd1, g);
      pv = pv & ~g;
    end
    idle(3);
    end_req = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t       e;
    rsp_t       r;
    logic [1:0] exp_rv;
    forever begin
      @(negedge clk);
      if (end_req) break;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("req_ready", req_ready, e.ready, e.cyc);
        chk("init_done", init_done, e.done, e.cyc);
        chk("rd_wr_exclusive", bank_read & bank_write, 0, e.cyc);
        if (e.rst) chk("reset_banksel", bank_banksel, 0, e.cyc);
        if (e.fill >= 0) begin
          chk("fill_addr", bank_address, e.fill, e.cyc);
          chk("fill_enables", {bank_banksel, bank_write, bank_read}, 3'b110, e.cyc);
          chk("fill_data", bank_wd, 0, e.cyc);
        end
        if (!e.rst && e.fill < 0) begin
          if (e.ready != 2'b00) begin
            chk("grant_addr", bank_address, e.addr, e.cyc);
            chk("grant_enables", {bank_banksel, bank_write, bank_read}, {1'b1, e.wr, !e.wr}, e.cyc);
          end else begin
            chk("idle_enables", {bank_banksel, bank_write, bank_read}, 3'b000, e.cyc);
          end
        end
        exp_rv = 2'b00;
        if (rq.size() > 0 && rq[0].due == e.cyc) begin
          r = rq.pop_front();
          exp_rv = r.port ? 2'b10 : 2'b01;
        end
        chk("rsp_valid", rsp_valid, exp_rv, e.cyc);
        if (exp_rv != 2'b00) chk("rsp_data", rsp_data, r.data, e.cyc);
      end
    end
    chk("rsp_drained", rq.size(), 0, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
